baud_gen_os: RTL

BAUD_GEN_OS -- requirements
Module: baud_gen_os

---
 rtl/baud_gen_os.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/baud_gen_os.sv
// Oversampling baud generator: integer divisor with shadowed, wrap-aligned reload.
// Optional fractional divisor accumulator enabled by defining BAUD_FRAC_EN.
module baud_gen_os #(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              SYNC,
  input  logic              DIV_LD,
  input  logic [DIV_W-1:0]  DIV_INT,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] DIV_FRAC,
`endif
  output logic              TICK_OS,
  output logic              TICK_BIT,
  output logic              DIV_ACK
);

  localparam int unsigned       BIT_W     = $clog2(OVERSAMPLE);
  localparam longint unsigned   DIV_RAW   = 64'(CLK_FREQ) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  RESET_DIV = (DIV_RAW < 64'd2) ? DIV_W'(2) : DIV_W'(DIV_RAW);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] os_cnt_r;
  logic [DIV_W-1:0] div_act_r;
  logic [DIV_W-1:0] div_shd_r;
  logic [DIV_W-1:0] div_cap_s;
  logic [DIV_W-1:0] div_next_s;
  logic [DIV_W-1:0] last_s;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             pend_r;
  logic             pend_next_s;
  logic             wrap_s;
  logic             apply_s;
  logic             bit_wrap_s;
  logic             tick_os_r;
  logic             tick_bit_r;
  logic             div_ack_r;

`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] RESET_FRAC =
    FRAC_W'((64'(CLK_FREQ) << FRAC_W) / (64'(BAUD_RATE) * 64'(OVERSAMPLE)));

  logic [FRAC_W-1:0] acc_r;
  logic [FRAC_W-1:0] frac_act_r;
  logic [FRAC_W-1:0] frac_shd_r;
  logic [FRAC_W-1:0] frac_next_s;
  logic [FRAC_W-1:0] frac_add_s;
  logic [FRAC_W-1:0] acc_sum_s;
  logic              carry_s;
  logic              ext_r;

  // Fraction selection and accumulator sum; a carry stretches the next period by one clock
  always_comb begin
    if (DIV_LD) begin
      frac_next_s = DIV_FRAC;
    end else begin
      frac_next_s = frac_shd_r;
    end
    if (apply_s) begin
      frac_add_s = frac_next_s;
    end else begin
      frac_add_s = frac_act_r;
    end
    {carry_s, acc_sum_s} = {1'b0, acc_r} + {1'b0, frac_add_s};
    if (ext_r) begin
      last_s = div_act_r;
    end else begin
      last_s = div_act_r - DIV_W'(1);
    end
  end

  // Fractional state: shadow capture, activation and per-wrap accumulation
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r      <= {FRAC_W{1'b0}};
      ext_r      <= 1'b0;
      frac_act_r <= RESET_FRAC;
      frac_shd_r <= RESET_FRAC;
    end else begin
      if (DIV_LD) begin
        frac_shd_r <= DIV_FRAC;
      end
      if (apply_s) begin
        frac_act_r <= frac_next_s;
      end
      if (SYNC) begin
        acc_r <= {FRAC_W{1'b0}};
        ext_r <= 1'b0;
      end else if (wrap_s) begin
        acc_r <= acc_sum_s;
        ext_r <= carry_s;
      end
    end
  end
`else
  logic [FRAC_W-1:0] unused_frac_s;
  assign unused_frac_s = {FRAC_W{1'b0}};
  assign last_s        = div_act_r - DIV_W'(1);
`endif

  // Clamp, pending-load resolution and wrap detection
  always_comb begin
    if (DIV_INT < DIV_W'(2)) begin
      div_cap_s = DIV_W'(2);
    end else begin
      div_cap_s = DIV_INT;
    end
    if (DIV_LD) begin
      div_next_s = div_cap_s;
    end else begin
      div_next_s = div_shd_r;
    end
    pend_next_s = DIV_LD | pend_r;
    wrap_s      = EN & ~SYNC & (os_cnt_r == last_s);
    apply_s     = pend_next_s & (SYNC | wrap_s);
    bit_wrap_s  = (bit_cnt_r == BIT_LAST);
  end

  // Counters, divisor registers and registered tick/ack outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      os_cnt_r   <= {DIV_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      div_act_r  <= RESET_DIV;
      div_shd_r  <= RESET_DIV;
      pend_r     <= 1'b0;
      tick_os_r  <= 1'b0;
      tick_bit_r <= 1'b0;
      div_ack_r  <= 1'b0;
    end else begin
      tick_os_r  <= wrap_s;
      tick_bit_r <= wrap_s & bit_wrap_s;
      div_ack_r  <= apply_s;
      pend_r     <= pend_next_s & ~apply_s;
      if (DIV_LD) begin
        div_shd_r <= div_cap_s;
      end
      // The divisor only changes when the counter restarts, so a period never mixes divisors
      if (apply_s) begin
        div_act_r <= div_next_s;
      end
      if (SYNC) begin
        os_cnt_r  <= {DIV_W{1'b0}};
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (wrap_s) begin
        os_cnt_r <= {DIV_W{1'b0}};
        if (bit_wrap_s) begin
          bit_cnt_r <= {BIT_W{1'b0}};
        end else begin
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end
      end else if (EN) begin
        os_cnt_r <= os_cnt_r + DIV_W'(1);
      end
    end
  end

  assign TICK_OS  = tick_os_r;
  assign TICK_BIT = tick_bit_r;
  assign DIV_ACK  = div_ack_r;

endmodule
